// File: rtl/bmux_arbiter_4.sv
// bmux_arbiter_4: round-robin arbiter driving a registered 4:1 mux onto a shared bus
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   req       - per-requester request, held for the whole ownership period
//   in_0..3   - requester data
//   grant     - one-hot owner (registered)
//   sel       - encoded owner index (registered)
//   bus_out   - selected data, one cycle behind grant
//   bus_valid - bus_out carries owner data
//   timeout   - one-cycle pulse on forced rotation
module bmux_arbiter_4 #(
  parameter int DATA_W   = 10,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_valid,
  output logic              timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  // with no hold limit the counter just saturates at all-ones
  localparam logic [CNT_W-1:0] SAT = MAX_HOLD == 0 ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  state_t            r_state, w_nxt_state;
  logic [1:0]        r_sel, r_ptr, w_nxt_sel, w_off, w_pick;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [3:0]        w_grant, w_others, w_rot;
  logic              w_any, w_own_req, w_expire, w_nxt_to;
  logic              r_timeout, r_valid;
  logic [DATA_W-1:0] r_bus, w_data;
  // Round-robin pick: rotate the candidate mask so bit 0 is (ptr+1), take the
  // lowest set bit. The owner sits at the last position and is masked out, so
  // the same search serves IDLE grants, releases and forced rotations.
  always_comb begin
    w_others  = req & ~w_grant;
    w_rot     = 4'({w_others, w_others} >> ({1'b0, r_ptr} + 3'd1));
    w_off     = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    w_pick    = r_ptr + 2'd1 + w_off;
    w_any     = |w_others;
    w_own_req = |(req & w_grant);
    // >= rather than == so a saturated counter still forces rotation later
    w_expire  = (MAX_HOLD != 0) && (r_cnt >= LIM);
  end
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_cnt   = r_cnt;
    w_nxt_to    = 1'b0;
    if (r_state == IDLE) begin
      if (w_any) begin
        w_nxt_state = OWNED;
        w_nxt_sel   = w_pick;
        w_nxt_cnt   = '0;
      end
    end else if (!w_own_req) begin
      // release has priority over expiry: direct handoff, no timeout pulse
      w_nxt_state = w_any ? OWNED : IDLE;
      w_nxt_sel   = w_any ? w_pick : r_sel;
      w_nxt_cnt   = '0;
    end else if (w_expire && w_any) begin
      w_nxt_sel = w_pick;
      w_nxt_cnt = '0;
      w_nxt_to  = 1'b1;
    end else begin
      w_nxt_cnt = (r_cnt >= SAT) ? r_cnt : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd3;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_bus     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_sel     <= w_nxt_sel;
      r_ptr     <= (w_nxt_state == OWNED) ? w_nxt_sel : r_ptr;
      r_cnt     <= w_nxt_cnt;
      r_timeout <= w_nxt_to;
      r_bus     <= |w_grant ? w_data : r_bus;
      r_valid   <= |w_grant;
    end
  end
  always_comb begin
    w_grant   = (r_state == OWNED) ? 4'b0001 << r_sel : 4'b0000;
    w_data    = r_sel == 2'd0 ? in_0 : r_sel == 2'd1 ? in_1 : r_sel == 2'd2 ? in_2 : in_3;
    grant     = w_grant;
    sel       = r_sel;
    bus_out   = r_bus;
    bus_valid = r_valid;
    timeout   = r_timeout;
  end
endmodule

// File: tb/tb_bmux_arbiter_4.sv
// tb_bmux_arbiter_4: table-driven and sequence checks of bmux_arbiter_4 through an expectation queue
module tb_bmux_arbiter_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic [9:0] in_0 = 10'h2A5, in_1 = 10'h1C3, in_2 = 10'h0F0, in_3 = 10'h333;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [9:0] bus_out;
  logic       bus_valid, timeout;
  int errors = 0, checks = 0;
  typedef struct {logic [3:0] g; logic [1:0] s; logic v; logic [9:0] b; logic t;} exp_t;
  typedef struct {logic rn; logic [3:0] r; exp_t e;} vec_t;
  exp_t q[$];
  vec_t tbl[23];
  logic [9:0] din[4];
  bmux_arbiter_4 dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .grant(grant), .sel(sel), .bus_out(bus_out), .bus_valid(bus_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic step(input logic rn, input logic [3:0] r, input exp_t e, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n = rn;
    req = r;
    q.push_back(e);
    @(posedge clk);
    #1;
    x = q.pop_front();
    checks++;
    if ({grant, sel, bus_valid, bus_out, timeout} !== {x.g, x.s, x.v, x.b, x.t}) begin
      errors++;
      $display("FAIL %s: got grant=%b sel=%0d valid=%b bus=%h timeout=%b, want grant=%b sel=%0d valid=%b bus=%h timeout=%b",
               nm, grant, sel, bus_valid, bus_out, timeout, x.g, x.s, x.v, x.b, x.t);
    end
  endtask
  initial begin
    exp_t e;
    int o, p;
    din[0] = in_0; din[1] = in_1; din[2] = in_2; din[3] = in_3;
    tbl[0]  = '{1'b0, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[1]  = '{1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[2]  = '{1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[3]  = '{1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[4]  = '{1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[5]  = '{1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[6]  = '{1'b1, 4'b0101, '{4'b0001, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[7]  = '{1'b1, 4'b0101, '{4'b0001, 2'd0, 1'b1, 10'h2A5, 1'b0}};
    tbl[8]  = '{1'b1, 4'b0100, '{4'b0100, 2'd2, 1'b1, 10'h2A5, 1'b0}};
    tbl[9]  = '{1'b1, 4'b0100, '{4'b0100, 2'd2, 1'b1, 10'h0F0, 1'b0}};
    tbl[10] = '{1'b1, 4'b0000, '{4'b0000, 2'd2, 1'b1, 10'h0F0, 1'b0}};
    tbl[11] = '{1'b1, 4'b0000, '{4'b0000, 2'd2, 1'b0, 10'h0F0, 1'b0}};
    tbl[12] = '{1'b1, 4'b1010, '{4'b1000, 2'd3, 1'b0, 10'h0F0, 1'b0}};
    tbl[13] = '{1'b1, 4'b0010, '{4'b0010, 2'd1, 1'b1, 10'h333, 1'b0}};
    tbl[14] = '{1'b1, 4'b0000, '{4'b0000, 2'd1, 1'b1, 10'h1C3, 1'b0}};
    tbl[15] = '{1'b1, 4'b0000, '{4'b0000, 2'd1, 1'b0, 10'h1C3, 1'b0}};
    tbl[16] = '{1'b1, 4'b1000, '{4'b1000, 2'd3, 1'b0, 10'h1C3, 1'b0}};
    tbl[17] = '{1'b1, 4'b1000, '{4'b1000, 2'd3, 1'b1, 10'h333, 1'b0}};
    tbl[18] = '{1'b0, 4'b1000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}};
    tbl[19] = '{1'b1, 4'b1000, '{4'b1000, 2'd3, 1'b0, 10'h000, 1'b0}};
    tbl[20] = '{1'b1, 4'b1000, '{4'b1000, 2'd3, 1'b1, 10'h333, 1'b0}};
    tbl[21] = '{1'b1, 4'b0000, '{4'b0000, 2'd3, 1'b1, 10'h333, 1'b0}};
    tbl[22] = '{1'b1, 4'b0000, '{4'b0000, 2'd3, 1'b0, 10'h333, 1'b0}};
    step(1'b0, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}, "reset");
    foreach (tbl[i]) step(tbl[i].rn, tbl[i].r, tbl[i].e, $sformatf("vec[%0d]", i));
    // lone requester held past the hold limit: never rotates, never times out
    for (int i = 0; i < 40; i++)
      step(1'b1, 4'b0010, '{4'b0010, 2'd1, i > 0, i > 0 ? 10'h1C3 : 10'h333, 1'b0}, $sformatf("hold1[%0d]", i));
    step(1'b1, 4'b0000, '{4'b0000, 2'd1, 1'b1, 10'h1C3, 1'b0}, "hold1_rel");
    step(1'b0, 4'b0000, '{4'b0000, 2'd0, 1'b0, 10'h000, 1'b0}, "reset2");
    // all four requesting: each owner keeps 15 cycles, order 0,1,2,3,0
    for (int n = 0; n < 65; n++) begin
      o = (n / 15) % 4;
      p = ((n - 1) / 15) % 4;
      e.g = 4'(1 << o);
      e.s = 2'(o);
      e.v = n > 0;
      e.b = n > 0 ? din[p] : 10'h000;
      e.t = n >= 15 && n % 15 == 0;
      step(1'b1, 4'b1111, e, $sformatf("rr[%0d]", n));
    end
    step(1'b1, 4'b0000, '{4'b0000, 2'd0, 1'b1, 10'h2A5, 1'b0}, "rr_rel");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
